com_uart_transmitter: RTL and testbench
=======================================

COM_UART_TRANSMITTER -- requirements
Module: com_uart_transmitter

Interface
REQ-001 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port baud_tick  input  1  one-clk-wide pulse, one per bit period.
REQ-004 SHALL have port data_out_buffer  input  8  byte to transmit, LSB sent first.
REQ-005 SHALL have port write_en  input  1  push data_out_buffer into TX FIFO.
REQ-006 SHALL have port fifo_full  output  1  FIFO holds 4 entries.
REQ-007 SHALL have port fifo_empty  output  1  FIFO holds 0 entries.
REQ-008 SHALL have port tx_busy  output  1  high while a frame is on the line.
REQ-009 SHALL have port tx_port  output  1  serial line, idle high, registered.
REQ-010 SHALL have port stop_bit_config  input  1  0 = 1 stop bit, 1 = 2 stop bits.
REQ-011 SHALL have port parity_bit_config  input  2  [1] parity enable; [0] 1 = odd, 0 = even.
REQ-012 SHALL have port data_bit_config  input  2  data bits = 5 + value (5..8).

Function
REQ-013 SHALL contain a 4-entry, 8-bit FIFO with 2-bit read/write pointers wrapping 3 -> 0 and a 3-bit occupancy count.
REQ-014 SHALL accept a write on any clk edge where write_en=1 and fifo_full=0; write_en while fifo_full=1 SHALL be dropped with no state change.
REQ-015 SHALL treat fifo_full as blocking writes even when a pop occurs in the same cycle.
REQ-016 SHALL, on simultaneous accepted write and pop, keep occupancy unchanged and advance both pointers.
REQ-017 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP1, STOP2; transitions only on clk edges where baud_tick=1.
REQ-018 SHALL, in IDLE with fifo_empty=0 on baud_tick: pop one entry into a shift register, latch all three config inputs, load bit counter with data-bit count, drive tx_port=0, enter START.
REQ-019 SHALL ignore config changes mid-frame; latched values govern the whole frame.
REQ-020 SHALL, on baud_tick in START or DATA with bits remaining, drive shift-register bit 0 on tx_port, shift right, decrement counter; remain/enter DATA.
REQ-021 SHALL, after the last data bit's period, go to PARITY if enabled, else STOP1.
REQ-022 SHALL drive parity bit = XOR of transmitted data bits (even), inverted for odd, making total ones even/odd respectively.
REQ-023 SHALL drive tx_port=1 in STOP1 and STOP2; STOP1 -> STOP2 if 2 stop bits latched, else -> IDLE; STOP2 -> IDLE.
REQ-024 SHALL allow IDLE to start the next frame on the very next baud_tick after the last stop period (back-to-back frames, no extra idle bit).
REQ-025 SHALL assert tx_busy from the edge driving the start bit until the edge returning to IDLE.
REQ-026 SHALL ignore baud_tick pulses on non-tick cycles; each bit lasts exactly one baud_tick interval.
REQ-027 SHALL produce frame length = 1 + N + P + S bit periods (N 5..8, P 0/1, S 1/2).

Reset
REQ-028 SHALL, while rst=1 irrespective of clk, force tx_port=1, tx_busy=0, fifo_empty=1, fifo_full=0, pointers/count 0, FSM IDLE, shift register 0.
REQ-029 SHALL, on reset mid-frame, abort the frame immediately and discard all FIFO contents.
REQ-030 SHALL begin normal operation on the first clk edge after rst deasserts.

Verification
REQ-031 8N1 (data_bit_config=3, parity=00, stop=0), write 0xA5, ticks -> tx_port per tick: 0,1,0,1,0,0,1,0,1,1 then idle 1; tx_busy high for 10 ticks.
REQ-032 7E1 (data_bit_config=2, parity=10), write 0x55 -> 0,1,0,1,0,1,0,1, parity 0, stop 1.
REQ-033 5O2 (data_bit_config=0, parity=11, stop=1), write 0x1F -> 0,1,1,1,1,1, parity 0, 1,1.
REQ-034 No ticks, write 0x01..0x05 on 5 consecutive clks -> fifo_full=1 after 4th, 0x05 dropped; ticks then send 0x01..0x04 back-to-back, fifo_empty=1 after 4th pop.
REQ-035 Assert rst during 3rd data bit of 0xA5 with 2 bytes queued -> tx_port=1, tx_busy=0, fifo_empty=1 immediately; no further frames after release.
REQ-036 Change data_bit_config 3 -> 0 mid-frame -> current frame still 8 data bits; next frame 5.

Source files
------------

// File: rtl/com_uart_transmitter.sv
// UART transmitter with a 4-entry byte FIFO.
// Frame: start bit, 5..8 data bits LSB first, optional even/odd parity,
// 1 or 2 stop bits. Every bit lasts exactly one baud_tick interval.
// Frame configuration is latched when a byte is popped, so config changes
// never affect a frame already on the line.
module com_uart_transmitter (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic [7:0] data_out_buffer,
    input  logic       write_en,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       tx_busy,
    output logic       tx_port,
    input  logic       stop_bit_config,
    input  logic [1:0] parity_bit_config,
    input  logic [1:0] data_bit_config
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP1  = 3'd4;
    localparam logic [2:0] S_STOP2  = 3'd5;

    logic [2:0] state_q,  state_d;
    logic [7:0] shreg_q,  shreg_d;
    logic [3:0] cnt_q,    cnt_d;
    logic       par_q,    par_d;     // running parity, seeded with odd flag
    logic       par_en_q, par_en_d;
    logic       stop2_q,  stop2_d;
    logic       busy_q,   busy_d;
    logic       tx_q,     tx_d;
    logic [7:0] mem_q [0:3];
    logic [7:0] mem_d [0:3];
    logic [1:0] wptr_q,   wptr_d;
    logic [1:0] rptr_q,   rptr_d;
    logic [2:0] count_q,  count_d;
    logic       full_q,   full_d;
    logic       empty_q,  empty_d;
    logic       push_s;
    logic       pop_s;
    logic       load_s;

    // Next-state logic for the framing FSM and the FIFO bookkeeping
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        par_d    = par_q;
        par_en_d = par_en_q;
        stop2_d  = stop2_q;
        busy_d   = busy_q;
        tx_d     = tx_q;
        mem_d    = mem_q;
        pop_s    = 1'b0;
        load_s   = 1'b0;
        // A full FIFO rejects writes even if a pop happens this cycle
        push_s   = write_en & ~full_q;

        if (baud_tick) begin
            case (state_q)
                S_IDLE: begin
                    load_s = ~empty_q;
                end
                S_START, S_DATA: begin
                    if (cnt_q != 4'd0) begin
                        tx_d    = shreg_q[0];
                        par_d   = par_q ^ shreg_q[0];
                        shreg_d = {1'b0, shreg_q[7:1]};
                        cnt_d   = cnt_q - 4'd1;
                        state_d = S_DATA;
                    end else if (par_en_q) begin
                        tx_d    = par_q;
                        state_d = S_PARITY;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_STOP1;
                    end
                end
                S_PARITY: begin
                    tx_d    = 1'b1;
                    state_d = S_STOP1;
                end
                S_STOP1: begin
                    tx_d = 1'b1;
                    if (stop2_q) begin
                        state_d = S_STOP2;
                    end else begin
                        // Last stop period ends: either chain the next frame or idle
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        load_s  = ~empty_q;
                    end
                end
                S_STOP2: begin
                    tx_d    = 1'b1;
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    load_s  = ~empty_q;
                end
                default: begin
                    tx_d    = 1'b1;
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        if (load_s) begin
            pop_s    = 1'b1;
            shreg_d  = mem_q[rptr_q];
            cnt_d    = 4'd5 + {2'b00, data_bit_config};
            par_en_d = parity_bit_config[1];
            par_d    = parity_bit_config[0];
            stop2_d  = stop_bit_config;
            tx_d     = 1'b0;
            busy_d   = 1'b1;
            state_d  = S_START;
        end else begin
            pop_s = 1'b0;
        end

        if (push_s) begin
            mem_d[wptr_q] = data_out_buffer;
        end else begin
            mem_d[wptr_q] = mem_q[wptr_q];
        end

        wptr_d  = push_s ? (wptr_q + 2'd1) : wptr_q;
        rptr_d  = pop_s  ? (rptr_q + 2'd1) : rptr_q;
        count_d = count_q + {2'b00, push_s} - {2'b00, pop_s};
        full_d  = (count_d == 3'd4);
        empty_d = (count_d == 3'd0);
    end

    // State registers; reset aborts any frame and flushes the FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            shreg_q  <= 8'h00;
            cnt_q    <= 4'd0;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
            busy_q   <= 1'b0;
            tx_q     <= 1'b1;
            mem_q    <= '{default: 8'h00};
            wptr_q   <= 2'd0;
            rptr_q   <= 2'd0;
            count_q  <= 3'd0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            par_q    <= par_d;
            par_en_q <= par_en_d;
            stop2_q  <= stop2_d;
            busy_q   <= busy_d;
            tx_q     <= tx_d;
            mem_q    <= mem_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign tx_port    = tx_q;
    assign tx_busy    = busy_q;
    assign fifo_full  = full_q;
    assign fifo_empty = empty_q;

endmodule

// File: tb/tb_com_uart_transmitter.sv
// Directed self-checking bench for com_uart_transmitter.
module tb_com_uart_transmitter;

    logic       clk;
    logic       rst;
    logic       baud_tick;
    logic [7:0] data_out_buffer;
    logic       write_en;
    logic       fifo_full;
    logic       fifo_empty;
    logic       tx_busy;
    logic       tx_port;
    logic       stop_bit_config;
    logic [1:0] parity_bit_config;
    logic [1:0] data_bit_config;

    int pass_cnt  = 0;
    int total_cnt = 0;

    com_uart_transmitter dut (
        .clk               (clk),
        .rst               (rst),
        .baud_tick         (baud_tick),
        .data_out_buffer   (data_out_buffer),
        .write_en          (write_en),
        .fifo_full         (fifo_full),
        .fifo_empty        (fifo_empty),
        .tx_busy           (tx_busy),
        .tx_port           (tx_port),
        .stop_bit_config   (stop_bit_config),
        .parity_bit_config (parity_bit_config),
        .data_bit_config   (data_bit_config)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One baud tick preceded by idle clocks; returns on the falling edge after the tick
    task automatic do_tick();
        repeat (2) @(negedge clk);
        baud_tick = 1'b1;
        @(negedge clk);
        baud_tick = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        data_out_buffer = b;
        write_en = 1'b1;
        @(negedge clk);
        write_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++; if (tx_port !== 1'b1) $display("FAIL rst_tx got %b want 1", tx_port); else pass_cnt++;
        total_cnt++; if (tx_busy !== 1'b0) $display("FAIL rst_busy got %b want 0", tx_busy); else pass_cnt++;
        total_cnt++; if (fifo_empty !== 1'b1) $display("FAIL rst_empty got %b want 1", fifo_empty); else pass_cnt++;
        total_cnt++; if (fifo_full !== 1'b0) $display("FAIL rst_full got %b want 0", fifo_full); else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_8n1();
        logic exp_q[$];
        exp_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        data_bit_config = 2'd3; parity_bit_config = 2'b00; stop_bit_config = 1'b0;
        push_byte(8'hA5);
        total_cnt++; if (fifo_empty !== 1'b0) $display("FAIL 8n1_empty got %b want 0", fifo_empty); else pass_cnt++;
        for (int i = 0; i < exp_q.size(); i++) begin
            do_tick();
            total_cnt++; if (tx_port !== exp_q[i]) $display("FAIL 8n1_bit%0d got %b want %b", i, tx_port, exp_q[i]); else pass_cnt++;
            total_cnt++; if (tx_busy !== 1'b1) $display("FAIL 8n1_busy%0d got %b want 1", i, tx_busy); else pass_cnt++;
        end
        do_tick();
        total_cnt++; if (tx_port !== 1'b1) $display("FAIL 8n1_idle_tx got %b want 1", tx_port); else pass_cnt++;
        total_cnt++; if (tx_busy !== 1'b0) $display("FAIL 8n1_idle_busy got %b want 0", tx_busy); else pass_cnt++;
    endtask

    task automatic test_7e1();
        logic exp_q[$];
        exp_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        data_bit_config = 2'd2; parity_bit_config = 2'b10; stop_bit_config = 1'b0;
        push_byte(8'h55);
        for (int i = 0; i < exp_q.size(); i++) begin
            do_tick();
            total_cnt++; if (tx_port !== exp_q[i]) $display("FAIL 7e1_bit%0d got %b want %b", i, tx_port, exp_q[i]); else pass_cnt++;
        end
        do_tick();
        total_cnt++; if (tx_busy !== 1'b0) $display("FAIL 7e1_idle_busy got %b want 0", tx_busy); else pass_cnt++;
    endtask

    task automatic test_5o2();
        logic exp_q[$];
        exp_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        data_bit_config = 2'd0; parity_bit_config = 2'b11; stop_bit_config = 1'b1;
        push_byte(8'h1F);
        for (int i = 0; i < exp_q.size(); i++) begin
            do_tick();
            total_cnt++; if (tx_port !== exp_q[i]) $display("FAIL 5o2_bit%0d got %b want %b", i, tx_port, exp_q[i]); else pass_cnt++;
            total_cnt++; if (tx_busy !== 1'b1) $display("FAIL 5o2_busy%0d got %b want 1", i, tx_busy); else pass_cnt++;
        end
        do_tick();
        total_cnt++; if (tx_busy !== 1'b0) $display("FAIL 5o2_idle_busy got %b want 0", tx_busy); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic exp_q[$];
        logic [7:0] b;
        data_bit_config = 2'd3; parity_bit_config = 2'b00; stop_bit_config = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 5) begin
                total_cnt++; if (fifo_full !== 1'b1) $display("FAIL fifo_full_after4 got %b want 1", fifo_full); else pass_cnt++;
            end
            data_out_buffer = 8'(i);
            write_en = 1'b1;
        end
        @(negedge clk);
        write_en = 1'b0;
        total_cnt++; if (fifo_full !== 1'b1) $display("FAIL fifo_full_hold got %b want 1", fifo_full); else pass_cnt++;
        for (int k = 1; k <= 4; k++) begin
            b = 8'(k);
            exp_q.push_back(1'b0);
            for (int j = 0; j < 8; j++) exp_q.push_back(b[j]);
            exp_q.push_back(1'b1);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            do_tick();
            total_cnt++; if (tx_port !== exp_q[i]) $display("FAIL b2b_bit%0d got %b want %b", i, tx_port, exp_q[i]); else pass_cnt++;
            total_cnt++; if (tx_busy !== 1'b1) $display("FAIL b2b_busy%0d got %b want 1", i, tx_busy); else pass_cnt++;
            if (i == 0) begin
                total_cnt++; if (fifo_full !== 1'b0) $display("FAIL b2b_full_after_pop got %b want 0", fifo_full); else pass_cnt++;
            end
            if (i == 30) begin
                total_cnt++; if (fifo_empty !== 1'b1) $display("FAIL b2b_empty_after4 got %b want 1", fifo_empty); else pass_cnt++;
            end
        end
        do_tick();
        total_cnt++; if (tx_port !== 1'b1) $display("FAIL b2b_dropped_tx got %b want 1", tx_port); else pass_cnt++;
        total_cnt++; if (tx_busy !== 1'b0) $display("FAIL b2b_dropped_busy got %b want 0", tx_busy); else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        data_bit_config = 2'd3; parity_bit_config = 2'b00; stop_bit_config = 1'b0;
        push_byte(8'hA5);
        push_byte(8'h11);
        push_byte(8'h22);
        // start bit, then first three data bits (third data bit of 0xA5 is 1)
        repeat (4) do_tick();
        total_cnt++; if (tx_port !== 1'b1) $display("FAIL mid_bit2 got %b want 1", tx_port); else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++; if (tx_port !== 1'b1) $display("FAIL mid_rst_tx got %b want 1", tx_port); else pass_cnt++;
        total_cnt++; if (tx_busy !== 1'b0) $display("FAIL mid_rst_busy got %b want 0", tx_busy); else pass_cnt++;
        total_cnt++; if (fifo_empty !== 1'b1) $display("FAIL mid_rst_empty got %b want 1", fifo_empty); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            do_tick();
            total_cnt++; if (tx_port !== 1'b1 || tx_busy !== 1'b0)
                $display("FAIL mid_after%0d got tx=%b busy=%b want tx=1 busy=0", i, tx_port, tx_busy);
            else pass_cnt++;
        end
    endtask

    task automatic test_config_change();
        logic exp_q[$];
        exp_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        data_bit_config = 2'd3; parity_bit_config = 2'b00; stop_bit_config = 1'b0;
        push_byte(8'h80);
        push_byte(8'h13);
        for (int i = 0; i < exp_q.size(); i++) begin
            do_tick();
            if (i == 0) data_bit_config = 2'd0;
            total_cnt++; if (tx_port !== exp_q[i]) $display("FAIL cfg_bit%0d got %b want %b", i, tx_port, exp_q[i]); else pass_cnt++;
        end
        do_tick();
        total_cnt++; if (tx_busy !== 1'b0) $display("FAIL cfg_idle_busy got %b want 0", tx_busy); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        baud_tick = 1'b0;
        data_out_buffer = 8'h00;
        write_en = 1'b0;
        stop_bit_config = 1'b0;
        parity_bit_config = 2'b00;
        data_bit_config = 2'd3;
        test_reset();
        test_8n1();
        test_7e1();
        test_5o2();
        test_back_to_back();
        test_reset_midframe();
        test_config_change();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
